// File: rtl/if_id_hazard_ctl_if.sv
// if_id_hazard_ctl_if
//   Bundles the fetch/decode hazard-response signals between the pipeline
//   front end (master) and the PC / IF-ID owner (slave).
//   master drives : en, stall, branch_taken, branch_target, if_inst
//   slave drives  : pc, id_inst, id_pc, id_valid, ex_bubble, in_stall,
//                   stall_cnt, flush_cnt
interface if_id_hazard_ctl_if #(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 en;
  logic                 stall;
  logic                 branch_taken;
  logic [PC_WIDTH-1:0]  branch_target;
  logic [31:0]          if_inst;
  logic [PC_WIDTH-1:0]  pc;
  logic [31:0]          id_inst;
  logic [PC_WIDTH-1:0]  id_pc;
  logic                 id_valid;
  logic                 ex_bubble;
  logic                 in_stall;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [CNT_WIDTH-1:0] flush_cnt;

  modport master (
    output en, stall, branch_taken, branch_target, if_inst,
    input  pc, id_inst, id_pc, id_valid, ex_bubble, in_stall, stall_cnt, flush_cnt
  );

  modport slave (
    input  en, stall, branch_taken, branch_target, if_inst,
    output pc, id_inst, id_pc, id_valid, ex_bubble, in_stall, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/if_id_hazard_ctl.sv
// if_id_hazard_ctl
//   Owns the PC register and the IF/ID pipeline register and carries out the
//   hazard detector's requests: a load-use stall freezes PC and IF/ID for one
//   cycle while a bubble is pushed into ID/EX; a taken branch redirects the PC
//   and flushes IF/ID with a NOP. Saturating counters track stalls and flushes.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-low reset
//     hz   - slave side of if_id_hazard_ctl_if (inputs: en, stall,
//            branch_taken, branch_target, if_inst; outputs: pc, id_inst,
//            id_pc, id_valid, ex_bubble, in_stall, stall_cnt, flush_cnt)
module if_id_hazard_ctl #(
  parameter int                  PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = {PC_WIDTH{1'b0}},
  parameter logic [31:0]         NOP_INST  = 32'h0000_0000,
  parameter int                  CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  if_id_hazard_ctl_if.slave      hz
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  localparam logic [PC_WIDTH-1:0] PC_STEP = {{(PC_WIDTH-3){1'b0}}, 3'b100};

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction

  logic [0:0]           state_q,     state_d;
  logic [PC_WIDTH-1:0]  pc_q,        pc_d;
  logic [31:0]          id_inst_q,   id_inst_d;
  logic [PC_WIDTH-1:0]  id_pc_q,     id_pc_d;
  logic                 id_valid_q,  id_valid_d;
  logic                 ex_bubble_q, ex_bubble_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  // Next-state selection: branch redirect beats stall beats normal advance.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    id_inst_d   = id_inst_q;
    id_pc_d     = id_pc_q;
    id_valid_d  = id_valid_q;
    ex_bubble_d = ex_bubble_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hz.en) begin
      if (hz.branch_taken) begin
        // Redirect from either state; a coincident stall is dropped.
        pc_d        = hz.branch_target;
        id_inst_d   = NOP_INST;
        id_pc_d     = pc_q;
        id_valid_d  = 1'b0;
        ex_bubble_d = 1'b0;
        state_d     = ST_RUN;
        flush_cnt_d = sat_inc(flush_cnt_q);
      end else begin
        case (state_q)
          ST_RUN: begin
            if (hz.stall) begin
              ex_bubble_d = 1'b1;
              state_d     = ST_STALL;
              stall_cnt_d = sat_inc(stall_cnt_q);
            end else begin
              pc_d        = pc_q + PC_STEP;
              id_inst_d   = hz.if_inst;
              id_pc_d     = pc_q;
              id_valid_d  = 1'b1;
              ex_bubble_d = 1'b0;
              state_d     = ST_RUN;
            end
          end
          ST_STALL: begin
            // Stall is ignored here: the load result is forwardable now, and
            // honouring it again would deadlock a held-high request.
            pc_d        = pc_q + PC_STEP;
            id_inst_d   = hz.if_inst;
            id_pc_d     = pc_q;
            id_valid_d  = 1'b1;
            ex_bubble_d = 1'b0;
            state_d     = ST_RUN;
          end
          default: begin
            state_d     = ST_RUN;
            ex_bubble_d = 1'b0;
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      id_inst_q   <= NOP_INST;
      id_pc_q     <= {PC_WIDTH{1'b0}};
      id_valid_q  <= 1'b0;
      ex_bubble_q <= 1'b0;
      stall_cnt_q <= {CNT_WIDTH{1'b0}};
      flush_cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      id_inst_q   <= id_inst_d;
      id_pc_q     <= id_pc_d;
      id_valid_q  <= id_valid_d;
      ex_bubble_q <= ex_bubble_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.pc        = pc_q;
  assign hz.id_inst   = id_inst_q;
  assign hz.id_pc     = id_pc_q;
  assign hz.id_valid  = id_valid_q;
  assign hz.ex_bubble = ex_bubble_q;
  assign hz.in_stall  = (state_q == ST_STALL);
  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_if_id_hazard_ctl.sv
// tb_if_id_hazard_ctl
//   Directed vector table, hand-written corner sequences and randomized
//   traffic against a cycle-level reference model of the hazard response.
module tb_if_id_hazard_ctl;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  if_id_hazard_ctl_if #(.PC_WIDTH(32), .CNT_WIDTH(CW)) ifc ();

  if_id_hazard_ctl #(
    .PC_WIDTH (32),
    .RESET_PC (32'h0000_0000),
    .NOP_INST (32'h0000_0000),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (ifc.slave)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: architectural view of the pipeline front end.
  logic [31:0] m_pc, m_inst, m_id_pc;
  bit          m_valid, m_bubble, m_just_stalled;
  int          m_sc, m_fc;

  task automatic model_reset();
    m_pc = 32'h0; m_inst = 32'h0; m_id_pc = 32'h0;
    m_valid = 1'b0; m_bubble = 1'b0; m_just_stalled = 1'b0;
    m_sc = 0; m_fc = 0;
  endtask

  task automatic model_step(input bit en, input bit st, input bit br,
                            input logic [31:0] tgt, input logic [31:0] inst);
    if (!en) return;
    if (br) begin
      m_id_pc = m_pc; m_pc = tgt; m_inst = 32'h0; m_valid = 1'b0;
      m_bubble = 1'b0; m_just_stalled = 1'b0;
      if (m_fc < CMAX) m_fc = m_fc + 1;
    end else if (st && !m_just_stalled) begin
      m_bubble = 1'b1; m_just_stalled = 1'b1;
      if (m_sc < CMAX) m_sc = m_sc + 1;
    end else begin
      m_id_pc = m_pc; m_pc = m_pc + 32'd4; m_inst = inst; m_valid = 1'b1;
      m_bubble = 1'b0; m_just_stalled = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pc"},        64'(ifc.pc),        64'(m_pc));
    chk({tag, ".id_inst"},   64'(ifc.id_inst),   64'(m_inst));
    chk({tag, ".id_pc"},     64'(ifc.id_pc),     64'(m_id_pc));
    chk({tag, ".id_valid"},  64'(ifc.id_valid),  64'(m_valid));
    chk({tag, ".ex_bubble"}, 64'(ifc.ex_bubble), 64'(m_bubble));
    chk({tag, ".in_stall"},  64'(ifc.in_stall),  64'(m_just_stalled));
    chk({tag, ".stall_cnt"}, 64'(ifc.stall_cnt), 64'(m_sc));
    chk({tag, ".flush_cnt"}, 64'(ifc.flush_cnt), 64'(m_fc));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".pc"},        64'(ifc.pc),        64'h0);
    chk({tag, ".id_inst"},   64'(ifc.id_inst),   64'h0);
    chk({tag, ".id_pc"},     64'(ifc.id_pc),     64'h0);
    chk({tag, ".id_valid"},  64'(ifc.id_valid),  64'h0);
    chk({tag, ".ex_bubble"}, 64'(ifc.ex_bubble), 64'h0);
    chk({tag, ".in_stall"},  64'(ifc.in_stall),  64'h0);
    chk({tag, ".stall_cnt"}, 64'(ifc.stall_cnt), 64'h0);
    chk({tag, ".flush_cnt"}, 64'(ifc.flush_cnt), 64'h0);
  endtask

  // Drive one cycle's inputs, advance the model, clock, then sample #1 later.
  task automatic do_cycle(input bit en, input bit st, input bit br,
                          input logic [31:0] tgt, input logic [31:0] inst, input string tag);
    ifc.en = en; ifc.stall = st; ifc.branch_taken = br;
    ifc.branch_target = tgt; ifc.if_inst = inst;
    model_step(en, st, br, tgt, inst);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  typedef struct {
    bit          en, st, br;
    logic [31:0] tgt, inst;
    logic [31:0] e_pc, e_inst, e_id_pc;
    bit          e_valid, e_bub, e_ins;
    logic [3:0]  e_sc, e_fc;
  } vec_t;

  vec_t tbl[18];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    ifc.en = 1'b0; ifc.stall = 1'b0; ifc.branch_taken = 1'b0;
    ifc.branch_target = 32'h0; ifc.if_inst = 32'h0;
    model_reset();

    //            en st br tgt          inst          e_pc          e_inst        e_id_pc     v  b  s  sc    fc
    tbl[0]  = '{1, 0, 0, 32'h0,       32'h2001_0005, 32'h4,       32'h2001_0005, 32'h0,     1, 0, 0, 4'd0, 4'd0};
    tbl[1]  = '{1, 0, 0, 32'h0,       32'h2001_0005, 32'h8,       32'h2001_0005, 32'h4,     1, 0, 0, 4'd0, 4'd0};
    tbl[2]  = '{1, 0, 0, 32'h0,       32'h2001_0005, 32'hC,       32'h2001_0005, 32'h8,     1, 0, 0, 4'd0, 4'd0};
    tbl[3]  = '{1, 0, 0, 32'h0,       32'hA000_0003, 32'h10,      32'hA000_0003, 32'hC,     1, 0, 0, 4'd0, 4'd0};
    tbl[4]  = '{1, 1, 0, 32'h0,       32'hA000_0004, 32'h10,      32'hA000_0003, 32'hC,     1, 1, 1, 4'd1, 4'd0};
    tbl[5]  = '{1, 0, 0, 32'h0,       32'hA000_0005, 32'h14,      32'hA000_0005, 32'h10,    1, 0, 0, 4'd1, 4'd0};
    tbl[6]  = '{1, 1, 0, 32'h0,       32'hA000_0006, 32'h14,      32'hA000_0005, 32'h10,    1, 1, 1, 4'd2, 4'd0};
    tbl[7]  = '{1, 1, 0, 32'h0,       32'hA000_0007, 32'h18,      32'hA000_0007, 32'h14,    1, 0, 0, 4'd2, 4'd0};
    tbl[8]  = '{1, 1, 0, 32'h0,       32'hA000_0008, 32'h18,      32'hA000_0007, 32'h14,    1, 1, 1, 4'd3, 4'd0};
    tbl[9]  = '{1, 1, 0, 32'h0,       32'hA000_0009, 32'h1C,      32'hA000_0009, 32'h18,    1, 0, 0, 4'd3, 4'd0};
    tbl[10] = '{1, 1, 1, 32'h400,     32'hA000_000A, 32'h400,     32'h0,         32'h1C,    0, 0, 0, 4'd3, 4'd1};
    tbl[11] = '{0, 1, 0, 32'h0,       32'hA000_000B, 32'h400,     32'h0,         32'h1C,    0, 0, 0, 4'd3, 4'd1};
    tbl[12] = '{0, 1, 0, 32'h0,       32'hA000_000C, 32'h400,     32'h0,         32'h1C,    0, 0, 0, 4'd3, 4'd1};
    tbl[13] = '{0, 1, 0, 32'h0,       32'hA000_000D, 32'h400,     32'h0,         32'h1C,    0, 0, 0, 4'd3, 4'd1};
    tbl[14] = '{1, 1, 0, 32'h0,       32'hA000_000E, 32'h400,     32'h0,         32'h1C,    0, 1, 1, 4'd4, 4'd1};
    tbl[15] = '{0, 0, 0, 32'h0,       32'hA000_000F, 32'h400,     32'h0,         32'h1C,    0, 1, 1, 4'd4, 4'd1};
    tbl[16] = '{1, 0, 1, 32'h800,     32'hB000_0000, 32'h800,     32'h0,         32'h400,   0, 0, 0, 4'd4, 4'd2};
    tbl[17] = '{1, 0, 0, 32'h0,       32'hB000_0001, 32'h804,     32'hB000_0001, 32'h800,   1, 0, 0, 4'd4, 4'd2};

    // Reset state while rst is held low.
    @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 18; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      do_cycle(tbl[i].en, tbl[i].st, tbl[i].br, tbl[i].tgt, tbl[i].inst, t);
      chk({t, ".tbl_pc"},        64'(ifc.pc),        64'(tbl[i].e_pc));
      chk({t, ".tbl_id_inst"},   64'(ifc.id_inst),   64'(tbl[i].e_inst));
      chk({t, ".tbl_id_pc"},     64'(ifc.id_pc),     64'(tbl[i].e_id_pc));
      chk({t, ".tbl_id_valid"},  64'(ifc.id_valid),  64'(tbl[i].e_valid));
      chk({t, ".tbl_ex_bubble"}, 64'(ifc.ex_bubble), 64'(tbl[i].e_bub));
      chk({t, ".tbl_in_stall"},  64'(ifc.in_stall),  64'(tbl[i].e_ins));
      chk({t, ".tbl_stall_cnt"}, 64'(ifc.stall_cnt), 64'(tbl[i].e_sc));
      chk({t, ".tbl_flush_cnt"}, 64'(ifc.flush_cnt), 64'(tbl[i].e_fc));
    end

    // PC wrap: redirect to the last word, then advance.
    do_cycle(1, 0, 1, 32'hFFFF_FFFC, 32'h0, "wrap_br");
    do_cycle(1, 0, 0, 32'h0, 32'hC0DE_0001, "wrap_adv");
    chk("wrap.pc_zero", 64'(ifc.pc), 64'h0);
    chk("wrap.id_pc", 64'(ifc.id_pc), 64'hFFFF_FFFC);

    // Counter saturation: 20 stalls and 20 flushes on a 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      do_cycle(1, 1, 0, 32'h0, 32'h1111_0000 + i, "sat_st");
      do_cycle(1, 0, 0, 32'h0, 32'h2222_0000 + i, "sat_adv");
    end
    chk("sat.stall_cnt", 64'(ifc.stall_cnt), 64'hF);
    for (int i = 0; i < 20; i++) begin
      do_cycle(1, 0, 1, 32'h100 + 32'(i * 4), 32'h0, "sat_br");
    end
    chk("sat.flush_cnt", 64'(ifc.flush_cnt), 64'hF);

    // Reset asserted while in STALL takes effect without a clock edge.
    do_cycle(1, 0, 0, 32'h0, 32'h3333_0000, "rst_pre");
    do_cycle(1, 1, 0, 32'h0, 32'h3333_0001, "rst_stall");
    chk("rst_stall.in_stall", 64'(ifc.in_stall), 64'h1);
    rst = 1'b0;
    #2;
    check_reset_vals("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        rst = 1'b0;
        #2;
        model_reset();
        check_reset_vals("rnd_rst");
        @(posedge clk);
        #1;
        rst = 1'b1;
      end else begin
        do_cycle($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 40,
                 $urandom_range(0, 99) < 12, $urandom & 32'hFFFF_FFFC, $urandom, "rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_hazard_ctl.md
Name: if_id_hazard_ctl

Overview:
- Response end of the load-use stall / forwarding protocol.
- The hazard detector raises `stall`; this block carries out the action by owning the PC register and the IF/ID pipeline register.
- Freezes PC and IF/ID for exactly one cycle, injects a bubble into ID/EX, and flushes IF/ID on a taken branch.
- Keeps saturating stall/flush performance counters.
- Sits between instruction fetch and the ID stage; its outputs feed the ID/EX register and the hazard detector's instruction inputs.

Parameters:
- PC_WIDTH, 32, width of PC and branch target.
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INST, 32'h0000_0000, instruction word loaded into IF/ID on flush or reset.
- CNT_WIDTH, 16, width of the performance counters.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- en  in  1  global pipeline enable; 0 freezes all state, including FSM and counters.
- stall  in  1  load-use stall request from the hazard detector; combinational, sampled at the clock edge.
- branch_taken  in  1  taken branch/jump resolved in ID.
- branch_target  in  PC_WIDTH  redirect address, valid while branch_taken=1.
- if_inst  in  32  instruction word fetched at the current `pc`.
- pc  out  PC_WIDTH  current fetch address (registered).
- id_inst  out  32  IF/ID instruction register.
- id_pc  out  PC_WIDTH  PC of id_inst.
- id_valid  out  1  id_inst is a real instruction, not a flush NOP.
- ex_bubble  out  1  registered; 1 forces ID/EX control signals to zero for this cycle.
- in_stall  out  1  FSM is in STALL.
- stall_cnt  out  CNT_WIDTH  count of stall cycles inserted, saturating.
- flush_cnt  out  CNT_WIDTH  count of branch flushes, saturating.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, id_inst=NOP_INST, id_pc=0.
  - id_valid=0, ex_bubble=0, in_stall=0.
  - stall_cnt=0, flush_cnt=0, FSM=RUN.
  - Asserting reset mid-stall or mid-redirect abandons the operation; no partial update survives.
- FSM states: RUN, STALL.
- All updates below happen on a rising edge with en=1. With en=0, every register holds, and ex_bubble keeps its value.
- Priority per edge: branch_taken > stall > normal advance.
- RUN, branch_taken=1:
  - pc<=branch_target; id_inst<=NOP_INST; id_valid<=0; id_pc<=pc.
  - ex_bubble<=0; FSM stays RUN; flush_cnt+1.
  - A stall asserted in the same cycle is dropped and stall_cnt does not increment.
- RUN, stall=1, branch_taken=0:
  - pc, id_inst, id_pc, id_valid hold.
  - ex_bubble<=1; FSM->STALL; stall_cnt+1.
- RUN, neither asserted:
  - pc<=pc+4, modulo 2^PC_WIDTH, so 32'hFFFF_FFFC wraps to 0.
  - id_inst<=if_inst; id_pc<=pc; id_valid<=1; ex_bubble<=0.
- STALL (exactly one cycle):
  - stall is ignored; the load result is now forwardable, and ignoring stall prevents deadlock.
  - Without branch: normal advance as in RUN, ex_bubble<=0, FSM->RUN.
  - With branch_taken=1: redirect as in RUN, flush_cnt+1, FSM->RUN.
- Back-to-back load-use: a stall asserted again on the first RUN cycle after STALL gives a new one-cycle stall. The minimum spacing of stall cycles is 2.
- Latency: redirect takes effect on `pc` one cycle after branch_taken is sampled. The penalty is exactly one NOP in IF/ID.
- Counters saturate at all-ones and never wrap.
- in_stall = (FSM==STALL).

Test Plan:
- Reset release: rst=0 then rst=1, en=1, no hazards, if_inst=32'h2001_0005 → after 3 edges pc=12, id_pc=8, id_valid=1, counters 0.
- Single load-use: at pc=0x10, assert stall for 1 cycle → pc and id_inst hold one cycle, ex_bubble=1 for exactly that cycle, stall_cnt=1, in_stall pulses once, then pc=0x14.
- Stall held high 4 cycles → pattern stall/advance/stall/advance: ex_bubble 1,0,1,0 and stall_cnt=2, with no deadlock.
- Branch vs stall: stall=1 and branch_taken=1 with branch_target=0x400 on the same edge → pc=0x400, id_inst=NOP_INST, id_valid=0, flush_cnt=1, stall_cnt=0, ex_bubble=0.
- en=0 for 3 cycles with stall=1 → no state change, counters unchanged; with en=1 the stall is then processed once.
- Wrap and saturation: pc=32'hFFFF_FFFC advances to 0; with CNT_WIDTH=4, 20 stalls → stall_cnt=4'hF. Reset asserted during STALL → all outputs at reset values immediately, without waiting for a clock edge.
